// File: rtl/split_2_l_alu.sv
// split_2_l_alu: 4-phase request fork steering loads/stores to lane 1 and ALU ops/NOP to lane 2.
// Optional macro SPLIT_ILLEGAL_TRAP_EN: illegal opcodes are acknowledged and dropped through TRAP.
module split_2_l_alu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       req_in,
    output logic       ack_out,
    output logic       req_out_1,
    input  logic       ack_in_1,
    output logic       req_out_2,
    input  logic       ack_in_2,
    input  logic       err_clr,
    output logic       err_illegal,
    output logic       busy
);
    localparam logic [1:0] LANE_MEM = 2'd1;
    localparam logic [1:0] LANE_ALU = 2'd2;

`ifdef SPLIT_ILLEGAL_TRAP_EN
    typedef enum logic [2:0] {IDLE, FWD, HOLD, RTZ, TRAP} state_t;
`else
    typedef enum logic [2:0] {IDLE, FWD, HOLD, RTZ} state_t;
`endif

    state_t     state_q, state_d;
    logic [1:0] lane_q, lane_d;
    logic       req1_q, req2_q, ack_q, busy_q;
    logic       req1_d, req2_d, ack_d, busy_d;
    logic       lane_ack;
`ifdef SPLIT_ILLEGAL_TRAP_EN
    logic       err_q;
    logic       err_set;
`else
    logic       unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

    function automatic logic is_mem(input logic [6:0] op);
        return (op == 7'b0000011) || (op == 7'b0100011);
    endfunction

    function automatic logic is_alu(input logic [6:0] op);
        return (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000000);
    endfunction

    // The acknowledge is chosen by the latched lane so opcode changes mid-handshake are harmless.
    assign lane_ack = (lane_q == LANE_MEM) ? ack_in_1 : ack_in_2;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
`ifdef SPLIT_ILLEGAL_TRAP_EN
        err_set = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_in) begin
                    if (is_mem(opcode)) begin
                        state_d = FWD;
                        lane_d  = LANE_MEM;
                    end else if (is_alu(opcode)) begin
                        state_d = FWD;
                        lane_d  = LANE_ALU;
                    end
`ifdef SPLIT_ILLEGAL_TRAP_EN
                    else begin
                        state_d = TRAP;
                        err_set = 1'b1;
                    end
`endif
                end
            end
            FWD:  if (lane_ack) state_d = HOLD;
            HOLD: if (!req_in) state_d = RTZ;
            RTZ:  if (!lane_ack) state_d = IDLE;
`ifdef SPLIT_ILLEGAL_TRAP_EN
            TRAP: if (!req_in) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

        // Outputs decode the next state so they register on the same edge as the transition.
        req1_d = ((state_d == FWD) || (state_d == HOLD)) && (lane_d == LANE_MEM);
        req2_d = ((state_d == FWD) || (state_d == HOLD)) && (lane_d == LANE_ALU);
        ack_d  = (state_d == HOLD) || (state_d == RTZ);
`ifdef SPLIT_ILLEGAL_TRAP_EN
        ack_d  = ack_d || (state_d == TRAP);
`endif
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lane_q  <= LANE_ALU;
            req1_q  <= 1'b0;
            req2_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SPLIT_ILLEGAL_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            req1_q  <= req1_d;
            req2_q  <= req2_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
`ifdef SPLIT_ILLEGAL_TRAP_EN
            // A fresh illegal detection outranks a simultaneous clear.
            if (err_set) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
`endif
        end
    end

    assign req_out_1 = req1_q;
    assign req_out_2 = req2_q;
    assign ack_out   = ack_q;
    assign busy      = busy_q;
`ifdef SPLIT_ILLEGAL_TRAP_EN
    assign err_illegal = err_q;
`else
    assign err_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_split_2_l_alu.sv
// Self-checking bench for split_2_l_alu: transaction-level lane/latency model driven by random stimulus.
module tb_split_2_l_alu;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       req_in = 1'b0;
    logic       ack_in_1 = 1'b0;
    logic       ack_in_2 = 1'b0;
    logic       err_clr = 1'b0;
    logic       ack_out, req_out_1, req_out_2, err_illegal, busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic err_exp = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    split_2_l_alu dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .req_in(req_in), .ack_out(ack_out),
        .req_out_1(req_out_1), .ack_in_1(ack_in_1), .req_out_2(req_out_2), .ack_in_2(ack_in_2),
        .err_clr(err_clr), .err_illegal(err_illegal), .busy(busy)
    );

    // Lane routing table: 1 = memory, 2 = ALU, 0 = illegal.
    function automatic int lane_of(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0100011:             return 1;
            7'b0110011, 7'b0010011, 7'b0000000: return 2;
            default:                            return 0;
        endcase
    endfunction

    function automatic logic [4:0] observed();
        return {req_out_1, req_out_2, ack_out, busy, err_illegal};
    endfunction

    function automatic logic [4:0] expected(input int lane, input bit req, input bit ack, input bit bsy);
        return {req && (lane == 1), req && (lane == 2), ack, bsy, err_exp};
    endfunction

    // One full 4-phase handshake; entered and left on a falling edge.
    task automatic run_txn(input logic [6:0] op, input int lat, input bit spur,
                           input bit switch_op, input logic [6:0] op_mid, input string tag);
        int lane = lane_of(op);
        logic [4:0] obs, exp;
        opcode = op;
        req_in = 1'b1;
        @(negedge clk);
        obs = observed(); exp = expected(lane, 1, 0, 1); checks++;
        if (obs !== exp) begin errors++; $display("FAIL %s_req got %b want %b", tag, obs, exp); end
        if (switch_op) opcode = op_mid;
        for (int i = 0; i < lat; i++) begin
            if (spur) begin
                if (lane == 1) ack_in_2 = (i == 0); else ack_in_1 = (i == 0);
            end
            @(negedge clk);
            obs = observed(); exp = expected(lane, 1, 0, 1); checks++;
            if (obs !== exp) begin errors++; $display("FAIL %s_wait%0d got %b want %b", tag, i, obs, exp); end
        end
        if (lane == 1) begin ack_in_1 = 1'b1; ack_in_2 = 1'b0; end
        else begin ack_in_2 = 1'b1; ack_in_1 = 1'b0; end
        @(negedge clk);
        obs = observed(); exp = expected(lane, 1, 1, 1); checks++;
        if (obs !== exp) begin errors++; $display("FAIL %s_ack got %b want %b", tag, obs, exp); end
        req_in = 1'b0;
        @(negedge clk);
        obs = observed(); exp = expected(lane, 0, 1, 1); checks++;
        if (obs !== exp) begin errors++; $display("FAIL %s_rtz got %b want %b", tag, obs, exp); end
        ack_in_1 = 1'b0;
        ack_in_2 = 1'b0;
        @(negedge clk);
        obs = observed(); exp = expected(lane, 0, 0, 0); checks++;
        if (obs !== exp) begin errors++; $display("FAIL %s_done got %b want %b", tag, obs, exp); end
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        obs = observed(); checks++;
        if (obs !== 5'b0) begin errors++; $display("FAIL reset_hold got %b want 00000", obs); end
        rst_n = 1'b1;
        @(negedge clk);
        obs = observed(); checks++;
        if (obs !== 5'b0) begin errors++; $display("FAIL reset_release got %b want 00000", obs); end
    endtask

    task automatic test_directed();
        run_txn(7'b0000011, 1, 0, 0, 7'd0, "load");
        run_txn(7'b0110011, 5, 1, 0, 7'd0, "alu_slow");
        run_txn(7'b0100011, 2, 0, 1, 7'b0010011, "opswitch");
        run_txn(7'b0010011, 0, 0, 0, 7'd0, "after_switch");
    endtask

    task automatic test_reset_mid_hold();
        logic [4:0] obs, exp;
        opcode = 7'b0000011;
        req_in = 1'b1;
        @(negedge clk);
        ack_in_1 = 1'b1;
        @(negedge clk);
        obs = observed(); exp = expected(1, 1, 1, 1); checks++;
        if (obs !== exp) begin errors++; $display("FAIL rst_hold_pre got %b want %b", obs, exp); end
        #2 rst_n = 1'b0;
        err_exp = 1'b0;
        #1;
        obs = observed(); checks++;
        if (obs !== 5'b0) begin errors++; $display("FAIL rst_async got %b want 00000", obs); end
        req_in = 1'b0;
        ack_in_1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        obs = observed(); checks++;
        if (obs !== 5'b0) begin errors++; $display("FAIL rst_idle got %b want 00000", obs); end
        run_txn(7'b0000000, 0, 0, 0, 7'd0, "nop_after_rst");
    endtask

    task automatic test_illegal();
        logic [4:0] obs, exp;
        opcode = 7'b1111111;
        req_in = 1'b1;
`ifdef SPLIT_ILLEGAL_TRAP_EN
        @(negedge clk);
        err_exp = 1'b1;
        obs = observed(); exp = expected(0, 0, 1, 1); checks++;
        if (obs !== exp) begin errors++; $display("FAIL trap_ack got %b want %b", obs, exp); end
        req_in = 1'b0;
        @(negedge clk);
        obs = observed(); exp = expected(0, 0, 0, 0); checks++;
        if (obs !== exp) begin errors++; $display("FAIL trap_done got %b want %b", obs, exp); end
        repeat (3) @(negedge clk);
        checks++;
        if (err_illegal !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err_illegal); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        err_exp = 1'b0;
        checks++;
        if (err_illegal !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", err_illegal); end
        err_clr = 1'b1;
        req_in = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        err_exp = 1'b1;
        obs = observed(); exp = expected(0, 0, 1, 1); checks++;
        if (obs !== exp) begin errors++; $display("FAIL set_beats_clr got %b want %b", obs, exp); end
        req_in = 1'b0;
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        err_exp = 1'b0;
        obs = observed(); exp = expected(0, 0, 0, 0); checks++;
        if (obs !== exp) begin errors++; $display("FAIL trap_exit_clr got %b want %b", obs, exp); end
        run_txn(7'b0000011, 0, 0, 0, 7'd0, "post_trap");
`else
        for (int i = 0; i < 10; i++) begin
            err_clr = i[0];
            @(negedge clk);
            obs = observed(); exp = expected(0, 0, 0, 0); checks++;
            if (obs !== exp) begin errors++; $display("FAIL illegal_idle%0d got %b want %b", i, obs, exp); end
        end
        err_clr = 1'b0;
        run_txn(7'b0000011, 0, 0, 0, 7'd0, "illegal_then_load");
`endif
    endtask

    task automatic test_back_to_back();
        int start;
        start = cyc;
        run_txn(7'b0000011, 0, 0, 0, 7'd0, "b2b_1");
        run_txn(7'b0110011, 0, 0, 0, 7'd0, "b2b_2");
        run_txn(7'b0000011, 0, 0, 0, 7'd0, "b2b_3");
        checks++;
        if (cyc - start !== 12) begin errors++; $display("FAIL b2b_cycles got %0d want 12", cyc - start); end
    endtask

    task automatic test_random();
        logic [6:0] legal [5];
        legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0000000};
        for (int n = 0; n < 25; n++) begin
            run_txn(legal[$urandom_range(4)], int'($urandom_range(4)), bit'($urandom_range(1)),
                    bit'($urandom_range(1)), legal[$urandom_range(4)], $sformatf("rnd%0d", n));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_hold();
        test_illegal();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/split_2_l_alu.md
# split_2_l_alu

Clocked 4-phase request splitter that steers one upstream instruction request to either the memory lane (loads/stores) or the ALU lane (R-type, I-type ops, NOP), based on the instruction opcode. It routes the selected lane's acknowledge back upstream. It sits at the issue stage, upstream of the two execution lanes. It is the fork counterpart of the lane merge that recombines the memory and ALU request channels.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- opcode  input  7  instruction opcode; must be stable while req_in is high.
- req_in  input  1  upstream 4-phase request.
- ack_out  output  1  upstream 4-phase acknowledge.
- req_out_1  output  1  request to memory lane (load 7'b0000011, store 7'b0100011).
- ack_in_1  input  1  acknowledge from memory lane.
- req_out_2  output  1  request to ALU lane (R 7'b0110011, I-op 7'b0010011, NOP 7'b0000000).
- ack_in_2  input  1  acknowledge from ALU lane.
- err_clr  input  1  synchronous clear of err_illegal.
- err_illegal  output  1  sticky illegal-opcode flag.
- busy  output  1  high in every state except IDLE.
- All inputs are synchronous to clk.

## Operation
- State machine: IDLE, FWD, HOLD, RTZ, TRAP.
- Lane register lane_q (1 = memory, 2 = ALU) is written only on IDLE->FWD; the lane ack is selected by lane_q, never by the live opcode.
- IDLE:
  - if req_in=1 and opcode is legal: latch lane_q, go to FWD.
  - if req_in=1 and opcode is illegal: see Configuration.
- FWD: req_out_<lane_q>=1; on ack_in_<lane_q>=1 go to HOLD.
- HOLD: req_out_<lane_q>=1, ack_out=1; on req_in=0 go to RTZ.
- RTZ: req_out_<lane_q>=0, ack_out=1; on ack_in_<lane_q>=0 go to IDLE (ack_out=0).
- Only one of req_out_1/req_out_2 is ever high; the other stays 0.
- Acknowledges from the non-selected lane are ignored in all states.
- Opcode changes after the IDLE sample have no effect until the next IDLE.
- All outputs are registered and decoded from state and lane_q.
- Reset (asserted at any time, including mid-handshake):
  - state=IDLE, lane_q=2.
  - req_out_1=0, req_out_2=0, ack_out=0, busy=0, err_illegal=0.
  - No partial handshake is resumed after reset.
- err_clr=1 clears err_illegal on the next edge. If err_clr and a new illegal detection coincide, the set wins.

## Timing
- Each transition takes effect on the first rising edge after its condition is sampled true: 1-cycle reaction per handshake phase.
- req_in rise to req_out_x rise: 1 cycle.
- ack_in_x rise to ack_out rise: 1 cycle.
- req_in fall to req_out_x fall: 1 cycle.
- ack_in_x fall to ack_out fall: 1 cycle.
- Minimum complete transaction: 4 cycles with zero-latency lanes.
- Back-to-back: if req_in is high in IDLE (ack_out already 0), the next transaction starts the same edge; no idle bubble is required.
- No combinational path from any input to any output.

## Configuration
- Macro SPLIT_ILLEGAL_TRAP_EN.
- Defined:
  - an illegal opcode in IDLE with req_in=1 goes to TRAP and sets err_illegal on that edge.
  - TRAP: ack_out=1, no lane request; on req_in=0 go to IDLE with ack_out=0.
  - The transaction is dropped but the upstream handshake completes.
- Undefined:
  - an illegal opcode holds IDLE (no ack, busy=0), and the opcode is re-evaluated every cycle until it is legal.
  - TRAP state and the err_illegal logic are absent; err_illegal is tied 0 and err_clr is ignored.

## Test plan
- Reset then load: opcode=7'b0000011, req_in=1, ack_in_1 returned 1 cycle after req_out_1 -> req_out_1 high at cycle 1, ack_out high at cycle 3; req_out_2 stays 0 throughout; full 4-phase completes.
- ALU path with slow lane: opcode=7'b0110011, ack_in_2 delayed 5 cycles -> state held in FWD for 5 cycles, ack_out rises exactly 1 cycle after ack_in_2; a spurious ack_in_1 pulse meanwhile has no effect.
- Opcode change mid-transaction: start with 7'b0100011, switch opcode to 7'b0010011 while in FWD -> remains on lane 1; the next transaction goes to lane 2.
- Reset mid-HOLD: assert rst_n=0 with ack_out=1 -> all outputs 0 asynchronously; after release, state is IDLE and a new NOP (7'b0000000) routes to lane 2.
- Illegal opcode 7'b1111111 with req_in=1:
  - macro defined: ack_out=1 next cycle, no req_out, err_illegal=1 until err_clr.
  - macro undefined: no response for 10 cycles; changing opcode to 7'b0000011 then starts lane 1.
- Back-to-back: three alternating load/R-type transactions with zero-latency lanes -> each completes in 4 cycles, 12 cycles total, lanes alternate 1,2,1.
